// File: rtl/akuma_pkg.sv
// Shared types and screen geometry for the Akuma sprite motion stage.
// Also holds the clamped horizontal step used for walking and airborne drift.
package akuma_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WALK = 2'd1,
      JUMP = 2'd2
   } motion_state_t;

   typedef enum logic [1:0] {
      NONE  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2
   } dir_t;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int SPRITE_W = 130;
   localparam int SPRITE_H = 240;

   // Widened to 11-bit signed so a left step near X_MIN cannot wrap around.
   function automatic logic [9:0] step_x(input logic [9:0] x,
                                         input dir_t       d,
                                         input int         step,
                                         input int         xmin,
                                         input int         xmax);
      logic signed [10:0] xs;
      logic signed [10:0] st;
      logic signed [10:0] lo;
      logic signed [10:0] hi;
      logic signed [10:0] t;
      xs = $signed({1'b0, x});
      st = 11'(step);
      lo = 11'(xmin);
      hi = 11'(xmax);
      t  = xs;
      case (d)
         LEFT: begin
            t = xs - st;
            if (t < lo) t = lo;
         end
         RIGHT: begin
            t = xs + st;
            if (t > hi) t = hi;
         end
         default: t = xs;
      endcase
      return t[9:0];
   endfunction

endpackage

// File: rtl/akuma_motion_vs_edge_tick.sv
// Registers the active-low vertical sync and flags its rising edge, which
// lands inside vertical blank and serves as the once-per-frame update strobe.
module vs_edge_tick (
   input  logic clk,
   input  logic rst,
   input  logic vs,
   output logic frame_tick
);

   logic vs_q;
   logic vs_d;

   always_comb begin
      vs_d = vs;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) vs_q <= 1'b1;
      else     vs_q <= vs_d;
   end

   assign frame_tick = vs & ~vs_q;

endmodule

// File: rtl/akuma_motion.sv
// Per-frame walk / clamp / gravity-jump motion for the Akuma sprite.
// Position and facing change only on the cycle after the frame tick.
module akuma_motion
   import akuma_pkg::*;
#(
   parameter int X_INIT    = 100,
   parameter int GROUND_Y  = SCREEN_H - SPRITE_H,
   parameter int X_MIN     = 0,
   parameter int X_MAX     = SCREEN_W - SPRITE_W,
   parameter int WALK_STEP = 4,
   parameter int JUMP_V0   = 12,
   parameter int GRAVITY   = 1
) (
   input  logic       vga_clk,
   input  logic       Reset,
   input  logic       vs,
   input  logic       move_left,
   input  logic       move_right,
   input  logic       jump,
   output logic [9:0] AkumaX,
   output logic [9:0] AkumaY,
   output logic       facing_right,
   output logic       airborne,
   output logic [1:0] motion_state
);

   localparam logic signed [10:0] GROUND_Y_S = 11'(GROUND_Y);
   localparam logic signed [7:0]  VY_LAUNCH  = 8'(GRAVITY - JUMP_V0);

   motion_state_t      state_q, state_d;
   logic [9:0]         x_q, x_d;
   logic [9:0]         y_q, y_d;
   logic signed [7:0]  vy_q, vy_d;
   dir_t               air_dir_q, air_dir_d;
   logic               facing_q, facing_d;
   logic               jump_q, jump_d;

   dir_t               dir;
   logic               launch;
   logic               frame_tick;
   logic signed [10:0] next_y;

   vs_edge_tick u_tick (
      .clk        (vga_clk),
      .rst        (Reset),
      .vs         (vs),
      .frame_tick (frame_tick)
   );

   // Both directions held cancel out rather than favouring one side.
   always_comb begin
      dir = NONE;
      if (move_left && !move_right)      dir = LEFT;
      else if (move_right && !move_left) dir = RIGHT;
   end

   assign launch = jump & ~jump_q;
   assign next_y = $signed({1'b0, y_q}) + $signed({{3{vy_q[7]}}, vy_q});

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      vy_d      = vy_q;
      air_dir_d = air_dir_q;
      facing_d  = facing_q;
      jump_d    = jump_q;
      if (frame_tick) begin
         jump_d = jump;
         case (state_q)
            JUMP: begin
               // Airborne drift follows the direction latched at launch.
               x_d = step_x(x_q, air_dir_q, WALK_STEP, X_MIN, X_MAX);
               if (!vy_q[7] && (next_y >= GROUND_Y_S)) begin
                  y_d     = 10'(GROUND_Y);
                  vy_d    = '0;
                  state_d = IDLE;
               end else begin
                  y_d  = next_y[9:0];
                  vy_d = vy_q + 8'(GRAVITY);
               end
            end
            default: begin
               if (launch) begin
                  state_d   = JUMP;
                  y_d       = y_q - 10'(JUMP_V0);
                  vy_d      = VY_LAUNCH;
                  air_dir_d = dir;
                  x_d       = step_x(x_q, dir, WALK_STEP, X_MIN, X_MAX);
               end else begin
                  x_d = step_x(x_q, dir, WALK_STEP, X_MIN, X_MAX);
                  case (dir)
                     LEFT: begin
                        facing_d = 1'b0;
                        state_d  = WALK;
                     end
                     RIGHT: begin
                        facing_d = 1'b1;
                        state_d  = WALK;
                     end
                     default: state_d = IDLE;
                  endcase
               end
            end
         endcase
      end
   end

   always_ff @(posedge vga_clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= IDLE;
         x_q       <= 10'(X_INIT);
         y_q       <= 10'(GROUND_Y);
         vy_q      <= '0;
         air_dir_q <= NONE;
         facing_q  <= 1'b1;
         jump_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         vy_q      <= vy_d;
         air_dir_q <= air_dir_d;
         facing_q  <= facing_d;
         jump_q    <= jump_d;
      end
   end

   assign AkumaX       = x_q;
   assign AkumaY       = y_q;
   assign facing_right = facing_q;
   assign airborne     = (state_q == JUMP);
   assign motion_state = state_q;

endmodule

// File: tb/tb_akuma_motion.sv
// Randomised and directed frame stimulus for akuma_motion, checked through a
// queue-based scoreboard against an integer-arithmetic motion model.
module tb_akuma_motion;

   logic       vga_clk = 1'b0;
   logic       Reset = 1'b0;
   logic       vs = 1'b1;
   logic       move_left = 1'b0;
   logic       move_right = 1'b0;
   logic       jump = 1'b0;
   logic [9:0] AkumaX;
   logic [9:0] AkumaY;
   logic       facing_right;
   logic       airborne;
   logic [1:0] motion_state;

   int errors = 0;
   int checks = 0;

   localparam logic [23:0] RST_VEC = {10'd100, 10'd240, 1'b1, 1'b0, 2'd0};

   // Model state: plain integers, state 0/1/2 = idle/walk/jump
   int mx, my, mvy, mst, mad, mfr, mjq;

   logic [23:0] exp_q[$];
   logic [23:0] held;
   logic        last_vs = 1'b1;
   bit          tick;
   logic [23:0] act_v;
   logic [23:0] exp_v;

   always #5 vga_clk = ~vga_clk;

   akuma_motion dut (
      .vga_clk      (vga_clk),
      .Reset        (Reset),
      .vs           (vs),
      .move_left    (move_left),
      .move_right   (move_right),
      .jump         (jump),
      .AkumaX       (AkumaX),
      .AkumaY       (AkumaY),
      .facing_right (facing_right),
      .airborne     (airborne),
      .motion_state (motion_state)
   );

   function automatic void model_reset();
      mx = 100; my = 240; mvy = 0; mst = 0; mad = 0; mfr = 1; mjq = 1;
   endfunction

   function automatic int clampx(input int v);
      if (v < 0)   return 0;
      if (v > 510) return 510;
      return v;
   endfunction

   function automatic logic [23:0] model_vec();
      return {10'(mx), 10'(my), 1'(mfr), (mst == 2), 2'(mst)};
   endfunction

   function automatic void model_step(input bit l, input bit r, input bit j);
      int  d;
      bit  launch;
      d      = (l && !r) ? -1 : ((r && !l) ? 1 : 0);
      launch = j && (mjq == 0);
      mjq    = j ? 1 : 0;
      if (mst != 2) begin
         if (launch) begin
            mst = 2; my = my - 12; mvy = -11; mad = d;
            mx  = clampx(mx + 4 * mad);
         end else if (d != 0) begin
            mx = clampx(mx + 4 * d); mfr = (d > 0) ? 1 : 0; mst = 1;
         end else begin
            mst = 0;
         end
      end else begin
         if (mvy >= 0 && my + mvy >= 240) begin
            my = 240; mvy = 0; mst = 0;
         end else begin
            my = my + mvy; mvy = mvy + 1;
         end
         mx = clampx(mx + 4 * mad);
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   // One frame: vs low for a few cycles with junk inputs, then inputs settle
   // and vs rises; returns at the negedge after the update edge.
   task automatic frame(input bit l, input bit r, input bit j);
      @(negedge vga_clk);
      vs = 1'b0;
      repeat ($urandom_range(1, 3)) begin
         move_left  = 1'($urandom_range(0, 1));
         move_right = 1'($urandom_range(0, 1));
         jump       = 1'($urandom_range(0, 1));
         @(negedge vga_clk);
      end
      move_left  = l;
      move_right = r;
      jump       = j;
      vs         = 1'b1;
      model_step(l, r, j);
      exp_q.push_back(model_vec());
      @(negedge vga_clk);
   endtask

   // Monitor: on a vs rising edge pop and compare; otherwise outputs must hold.
   initial begin
      forever begin
         @(posedge vga_clk);
         tick    = vs && !last_vs;
         last_vs = vs;
         if (Reset) begin
            held = RST_VEC;
         end else begin
            #1;
            act_v = {AkumaX, AkumaY, facing_right, airborne, motion_state};
            if (tick) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL tick_no_expect: got %h expected none", act_v);
               end else begin
                  exp_v = exp_q.pop_front();
                  if (act_v !== exp_v) begin
                     errors++;
                     $display("FAIL tick: got x=%0d y=%0d fr=%0d air=%0d st=%0d expected x=%0d y=%0d fr=%0d air=%0d st=%0d",
                              act_v[23:14], act_v[13:4], act_v[3], act_v[2], act_v[1:0],
                              exp_v[23:14], exp_v[13:4], exp_v[3], exp_v[2], exp_v[1:0]);
                  end
                  held = exp_v;
               end
            end else begin
               checks++;
               if (act_v !== held) begin
                  errors++;
                  $display("FAIL hold: got %h expected %h", act_v, held);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_reset_vals(input string tag);
      chk({tag, "_x"},   32'(AkumaX), 32'd100);
      chk({tag, "_y"},   32'(AkumaY), 32'd240);
      chk({tag, "_fr"},  32'(facing_right), 32'd1);
      chk({tag, "_st"},  32'(motion_state), 32'd0);
      chk({tag, "_air"}, 32'(airborne), 32'd0);
   endtask

   initial begin
      model_reset();
      #1 Reset = 1'b1;
      #2 check_reset_vals("reset");
      repeat (2) @(negedge vga_clk);
      Reset = 1'b0;

      // Walk right three ticks then release
      frame(0, 1, 0); chk("walk_x1", 32'(AkumaX), 32'd104);
      frame(0, 1, 0); chk("walk_x2", 32'(AkumaX), 32'd108);
      frame(0, 1, 0); chk("walk_x3", 32'(AkumaX), 32'd112);
      chk("walk_st", 32'(motion_state), 32'd1);
      frame(0, 0, 0); chk("idle_st", 32'(motion_state), 32'd0);
      chk("idle_x", 32'(AkumaX), 32'd112);

      // Clamp at both edges
      while (mx != 510) frame(0, 1, 0);
      while (mx != 2) frame(1, 0, 0);
      frame(1, 0, 0);
      chk("clamp_left_x", 32'(AkumaX), 32'd0);
      chk("clamp_left_fr", 32'(facing_right), 32'd0);
      while (mx != 508) frame(0, 1, 0);
      frame(0, 1, 0);
      chk("clamp_right_x", 32'(AkumaX), 32'd510);

      // Vertical jump trajectory
      frame(0, 0, 1); chk("jump_launch_y", 32'(AkumaY), 32'd228);
      for (int k = 2; k <= 25; k++) begin
         frame(0, 0, 0);
         if (k == 12) chk("jump_peak12", 32'(AkumaY), 32'd162);
         if (k == 13) chk("jump_peak13", 32'(AkumaY), 32'd162);
         if (k == 24) chk("jump_air24", 32'(airborne), 32'd1);
      end
      chk("land_y", 32'(AkumaY), 32'd240);
      chk("land_st", 32'(motion_state), 32'd0);

      // Held jump must not relaunch
      frame(0, 0, 1);
      repeat (30) frame(0, 0, 1);
      chk("no_relaunch", 32'(motion_state), 32'd0);
      frame(0, 0, 0);
      frame(0, 0, 1);
      chk("relaunch", 32'(motion_state), 32'd2);
      while (mst != 0) frame(0, 0, 0);

      // Both directions held
      frame(1, 1, 0);
      chk("both_x", 32'(AkumaX), 32'd510);
      chk("both_st", 32'(motion_state), 32'd0);

      // Asynchronous reset mid-jump
      frame(0, 0, 1);
      repeat (3) frame(0, 0, 0);
      @(posedge vga_clk);
      #3 Reset = 1'b1;
      #1 check_reset_vals("midjump_reset");
      model_reset();
      @(negedge vga_clk);
      @(negedge vga_clk);
      Reset = 1'b0;

      // Jump right, then push left mid-air
      frame(0, 1, 0);
      frame(0, 1, 1);
      repeat (24) frame(1, 0, 0);
      chk("air_dir_x", 32'(AkumaX), 32'd204);
      chk("air_dir_fr", 32'(facing_right), 32'd1);
      chk("air_dir_st", 32'(motion_state), 32'd0);

      // Random frames
      repeat (300) begin
         frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0));
      end

      repeat (3) @(negedge vga_clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
